// File: rtl/wb_uart_fifo.sv
// Wishbone-attached 8N1 UART with RX/TX FIFOs, runtime baud divisor,
// sticky error flags and maskable level interrupt.

module wb_uart_fifo_buf #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from the registered count, so same-cycle pops never unblock a push
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module wb_uart_fifo #(
  parameter int unsigned clk_freq = 50000000,
  parameter int unsigned baud     = 115200,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic        uart_rxd,
  output logic        uart_txd
);
  localparam int unsigned DIV_RST = clk_freq / baud - 1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic              ack_q, req, wr, rd;
  logic [2:0]        reg_sel;
  logic [2:0]        ctrl;
  logic [15:0]       div, div_eff;
  logic              rx_ferr, rx_ovr, tx_ovf;
  logic [2:0]        flag_clr;
  logic [31:0]       rd_data;

  logic              tx_push, tx_pop, tx_full, tx_fifo_empty;
  logic [7:0]        tx_rdata;
  logic [FIFO_AW:0]  tx_count;
  logic              rx_pop, rx_full, rx_fifo_empty;
  logic [7:0]        rx_rdata;
  logic [FIFO_AW:0]  rx_count;
  logic              tx_empty, rx_avail;

  logic unused;
  assign unused = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:16]};

  assign req      = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr       = req & wb_we_i & wb_sel_i[0];
  assign rd       = req & ~wb_we_i;
  assign reg_sel  = wb_adr_i[4:2];
  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;
  assign div_eff  = (div < 16'd2) ? 16'd2 : div;
  assign flag_clr = (wr && reg_sel == 3'd0) ? wb_dat_i[5:3] : 3'b000;
  assign tx_push  = wr && reg_sel == 3'd1;
  assign rx_pop   = rd && reg_sel == 3'd1;

  wb_uart_fifo_buf #(.AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .wdata(wb_dat_i[7:0]), .pop(tx_pop),
    .rdata(tx_rdata), .count(tx_count), .full(tx_full), .empty(tx_fifo_empty)
  );

  logic rx_push_q;
  logic [7:0] rx_shift;

  wb_uart_fifo_buf #(.AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push_q), .wdata(rx_shift), .pop(rx_pop),
    .rdata(rx_rdata), .count(rx_count), .full(rx_full), .empty(rx_fifo_empty)
  );

  // ---------------- TX engine ----------------
  tx_state_t   tx_state, tx_state_d;
  logic [15:0] tx_cnt, tx_cnt_d, tx_div, tx_div_d;
  logic [7:0]  tx_shift, tx_shift_d;
  logic [2:0]  tx_bit, tx_bit_d;
  logic        tx_busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_div    <= '0;
      tx_shift  <= '0;
      tx_bit    <= '0;
      tx_busy_q <= 1'b0;
      uart_txd  <= 1'b1;
    end else begin
      tx_state  <= tx_state_d;
      tx_cnt    <= tx_cnt_d;
      tx_div    <= tx_div_d;
      tx_shift  <= tx_shift_d;
      tx_bit    <= tx_bit_d;
      tx_busy_q <= (tx_state != TX_IDLE);
      // Line follows the engine one cycle later; frame timing is unaffected
      case (tx_state)
        TX_START: uart_txd <= 1'b0;
        TX_DATA:  uart_txd <= tx_shift[0];
        default:  uart_txd <= 1'b1;
      endcase
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_div_d   = tx_div;
    tx_shift_d = tx_shift;
    tx_bit_d   = tx_bit;
    tx_pop     = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (!tx_fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_rdata;
          tx_div_d   = div_eff;
          tx_cnt_d   = div_eff;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_d   = tx_div;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt - 16'd1;
      end
      TX_DATA: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_d   = tx_div;
          tx_shift_d = {1'b0, tx_shift[7:1]};
          tx_bit_d   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_d = TX_STOP;
        end else tx_cnt_d = tx_cnt - 16'd1;
      end
      TX_STOP: begin
        if (tx_cnt == 16'd0) tx_state_d = TX_IDLE;
        else tx_cnt_d = tx_cnt - 16'd1;
      end
    endcase
  end

  assign tx_empty = tx_fifo_empty & (tx_state == TX_IDLE) & ~tx_busy_q;
  assign rx_avail = ~rx_fifo_empty;

  // ---------------- RX engine ----------------
  rx_state_t   rx_state, rx_state_d;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_cnt, rx_cnt_d, rx_div, rx_div_d;
  logic [7:0]  rx_shift_d;
  logic [2:0]  rx_bit, rx_bit_d;
  logic        rx_push_d, rx_ferr_set;
  logic [16:0] rx_half;

  assign rx_half = ({1'b0, div_eff} + 17'd1) >> 1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_div    <= '0;
      rx_shift  <= '0;
      rx_bit    <= '0;
      rx_push_q <= 1'b0;
    end else begin
      rx_s1     <= uart_rxd;
      rx_s2     <= rx_s1;
      rx_prev   <= rx_s2;
      rx_state  <= rx_state_d;
      rx_cnt    <= rx_cnt_d;
      rx_div    <= rx_div_d;
      rx_shift  <= rx_shift_d;
      rx_bit    <= rx_bit_d;
      rx_push_q <= rx_push_d;
    end
  end

  always_comb begin
    rx_state_d  = rx_state;
    rx_cnt_d    = rx_cnt;
    rx_div_d    = rx_div;
    rx_shift_d  = rx_shift;
    rx_bit_d    = rx_bit;
    rx_push_d   = 1'b0;
    rx_ferr_set = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_div_d   = div_eff;
          rx_cnt_d   = 16'(rx_half - 17'd1);
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == 16'd0) begin
          if (rx_s2) rx_state_d = RX_IDLE;
          else begin
            rx_cnt_d   = rx_div;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else rx_cnt_d = rx_cnt - 16'd1;
      end
      RX_DATA: begin
        if (rx_cnt == 16'd0) begin
          rx_cnt_d   = rx_div;
          rx_shift_d = {rx_s2, rx_shift[7:1]};
          rx_bit_d   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
        end else rx_cnt_d = rx_cnt - 16'd1;
      end
      RX_STOP: begin
        if (rx_cnt == 16'd0) begin
          if (rx_s2) rx_push_d = 1'b1;
          else rx_ferr_set = 1'b1;
          rx_state_d = RX_IDLE;
        end else rx_cnt_d = rx_cnt - 16'd1;
      end
    endcase
  end

  // Register read mux
  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      3'd0:    rd_data = {26'd0, tx_ovf, rx_ovr, rx_ferr, tx_full, tx_empty, rx_avail};
      3'd1:    rd_data = rx_fifo_empty ? 32'd0 : {24'd0, rx_rdata};
      3'd2:    rd_data = {29'd0, ctrl};
      3'd3:    rd_data = {16'd0, div};
      3'd4:    rd_data = {16'd0, 8'(tx_count), 8'(rx_count)};
      default: rd_data = 32'd0;
    endcase
  end

  // Bus, control registers, sticky flags (set beats clear) and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q    <= 1'b0;
      wb_dat_o <= 32'd0;
      ctrl     <= 3'd0;
      div      <= 16'(DIV_RST);
      rx_ferr  <= 1'b0;
      rx_ovr   <= 1'b0;
      tx_ovf   <= 1'b0;
      intr     <= 1'b0;
    end else begin
      ack_q    <= req;
      wb_dat_o <= rd ? rd_data : 32'd0;
      if (wr && reg_sel == 3'd2) ctrl <= wb_dat_i[2:0];
      if (wr && reg_sel == 3'd3) div  <= wb_dat_i[15:0];
      rx_ferr  <= rx_ferr_set | (rx_ferr & ~flag_clr[0]);
      rx_ovr   <= (rx_push_q & rx_full) | (rx_ovr & ~flag_clr[1]);
      tx_ovf   <= (tx_push & tx_full) | (tx_ovf & ~flag_clr[2]);
      intr     <= (ctrl[0] & rx_avail) | (ctrl[1] & tx_empty) |
                  (ctrl[2] & (rx_ferr | rx_ovr | tx_ovf));
    end
  end
endmodule

// File: doc/wb_uart_fifo.md
# wb_uart_fifo

Wishbone-attached 8N1 UART with parametrised RX and TX FIFOs, a runtime-programmable baud divisor, sticky error flags and maskable interrupt sources. It is the next-generation console/serial peripheral on the SoC Wishbone bus. It integrates its own serializer and deserializer, so software can burst up to `FIFO_DEPTH` bytes per direction without polling per byte.

## Interface
- `clk_freq`, 50000000: system clock in Hz; used only for the DIV reset value.
- `baud`, 115200: reset baud rate; DIV resets to `clk_freq/baud - 1`, truncated to 16 bits.
- `FIFO_AW`, 4: FIFO address width, legal 1..7; `FIFO_DEPTH = 2**FIFO_AW`.
- `clk` input 1: system clock; everything is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `wb_stb_i`, `wb_cyc_i`, `wb_we_i` inputs 1: Wishbone strobe, cycle and write enable.
- `wb_adr_i` input 32: byte address; `[4:2]` selects the register.
- `wb_sel_i` input 4: byte selects; a write takes effect only if `[0]` is set.
- `wb_dat_i` input 32: write data.
- `wb_dat_o` output 32: read data, registered; bits not defined by a register read as 0.
- `wb_ack_o` output 1: `stb & cyc & ack_q`.
- `intr` output 1: level interrupt, active high.
- `uart_rxd` input 1: serial in, asynchronous.
- `uart_txd` output 1: serial out, idle high.

## Operation
Registers, selected by `wb_adr_i[4:2]`:
- **0 STAT**
  - Read layout: `{26'b0, tx_ovf, rx_ovr, rx_ferr, tx_full, tx_empty, rx_avail}`.
  - `tx_empty` = TX FIFO empty and transmitter idle.
  - Writing 1 to bits 5..3 clears the corresponding sticky flag.
- **1 DATA**
  - Read: pops the RX FIFO. If the FIFO is empty it returns 0 and does not pop.
  - Write: pushes `wb_dat_i[7:0]` to the TX FIFO. If the FIFO is full the byte is dropped and `tx_ovf` is set.
- **2 CTRL**
  - R/W, reset 0.
  - `[0]` rx_ie, `[1]` tx_ie, `[2]` err_ie.
- **3 DIV**
  - R/W `[15:0]`.
  - Bit period is DIV+1 clocks; DIV<2 is treated as 2.
- **4 LEVEL**
  - Read-only: `{16'b0, tx_count[7:0], rx_count[7:0]}`, counts 0..FIFO_DEPTH.
- **Addresses 5..7:** read 0; writes ignored.

FIFOs:
- Each FIFO has a circular buffer, wrapping read/write pointers and a `FIFO_AW+1`-bit count.
- Full/empty are judged at the start of the cycle, so a push while full is dropped even if a pop occurs in the same cycle.
- A pop while empty is ignored.
- A push and a pop in the same cycle, when neither is blocked, leave the count unchanged.

TX engine (states IDLE → START → DATA → STOP → IDLE):
- In IDLE with the FIFO non-empty, it pops one byte and latches the byte and DIV.
- It drives 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1), each for DIV+1 clocks.
- On return to IDLE it may start the next byte on the following cycle.

RX engine (states IDLE → START → DATA → STOP):
- `uart_rxd` passes through a 2-flop synchronizer.
- Start is detected on a 1→0 edge in IDLE; DIV is latched at that point.
- The start bit is re-sampled at (DIV+1)/2 clocks. If it is high, the engine returns to IDLE (glitch, no flag).
- Data bits are sampled every DIV+1 clocks from there, followed by the stop bit.
- If the stop bit is 0, `rx_ferr` is set and the byte is discarded.
- If the stop bit is 1 and the RX FIFO is full, `rx_ovr` is set and the byte is discarded; otherwise the byte is pushed.

Interrupt:
- `intr = (rx_ie & rx_avail) | (tx_ie & tx_empty) | (err_ie & (rx_ferr|rx_ovr|tx_ovf))`.

## Timing
- **Ack:** a request in cycle N with `ack_q=0` sets `ack_q` in N+1, so `wb_ack_o` is high in N+1. `ack_q` clears in N+2, which gives one ack per access and a minimum of 2 cycles per access.
- **Register side effects:** pushes, pops, flag clears and CTRL/DIV writes all happen at the edge ending cycle N.
- **Read data:** `wb_dat_o` is valid during the ack cycle.
- **RX pop timing:** a DATA read returns the head entry and pops in the same edge. `rx_count` is visible decremented on the next access.
- **TX latency:** a push into an empty, idle TX path drives `uart_txd` low 2 cycles after the write edge.
- **Frame length:** exactly 10·(DIV+1) clocks per TX frame.
- **RX push latency:** an RX byte is pushed 1 cycle after the stop-bit sample.
- **Flag priority:** a sticky flag that is set and cleared in the same cycle ends up set (set wins).
- **DIV changes:** a DIV write mid-frame affects only subsequent frames.
- **Reset values:**
  - `uart_txd`=1, `wb_ack_o`=0, `wb_dat_o`=0, `intr`=0.
  - FIFOs empty, flags 0, CTRL=0, DIV=`clk_freq/baud-1`.
  - Both engines in IDLE.
- **Reset mid-frame:** the TX frame is aborted and `uart_txd` is 1 from the next cycle; any partially received RX byte is discarded.

## Test plan
- **Reset:** after reset with defaults → STAT=0x02, DIV=433, LEVEL=0, `uart_txd`=1, `intr`=0.
- **TX burst:** DIV=3; write 0x55 then 0xA3 to DATA → two back-to-back frames of 40 clocks each, bits LSB first. `tx_empty`=1 only after the second stop bit.
- **RX fill, overrun and drain:** DIV=3, FIFO_AW=2; drive 5 frames 0x01..0x05 into `uart_rxd`.
  - Expect LEVEL=0x0004 and `rx_ovr`=1.
  - Four DATA reads return 0x01..0x04; a fifth read returns 0 and LEVEL stays 0.
- **Framing error:** a frame with stop=0 → `rx_ferr`=1, no push. With err_ie=1, `intr` goes high; writing STAT=0x08 clears the flag and `intr`.
- **TX overflow:** with the transmitter stalled mid-frame, write FIFO_DEPTH+2 bytes → `tx_ovf`=1 and `tx_count`=FIFO_DEPTH (one byte already popped by the engine).
- **Glitch and reset:** a 1-clock low pulse on `uart_rxd` → no push, no flag. Asserting `reset` mid-TX → `uart_txd`=1 the next cycle and LEVEL=0.
